// File: rtl/lotr_rst_seq.sv
// Reset sequencer and run watchdog for the lotr fabric: resynchronises the board
// reset release, frees cores one by one, and handles software per-core reset pulses.
module lotr_rst_seq #(
   parameter int NUM_CORES   = 4,
   parameter int SYNC_STAGES = 2,
   parameter int STAGGER     = 8,
   parameter int TIMEOUT     = 1000,
   parameter int CNT_W       = 32
) (
   input  logic                 QClk,
   input  logic                 RstQnnnL,
   input  logic                 SwRstReq,
   input  logic [3:0]           SwRstIdx,
   output logic [NUM_CORES-1:0] CoreRstQnnnH,
   output logic                 AllOutOfRst,
   output logic                 SwRstBusy,
   output logic                 SwRstErr,
   output logic                 Timeout,
   output logic [CNT_W-1:0]     RunCycles
);

   localparam int SCW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
   localparam logic [SCW-1:0]       STG_LAST  = SCW'(STAGGER - 1);
   localparam logic [3:0]           LAST_CORE = 4'(NUM_CORES - 1);
   localparam logic [4:0]           NUM_C5    = 5'(NUM_CORES);
   localparam logic [CNT_W-1:0]     TO_VAL    = CNT_W'(TIMEOUT);
   localparam logic [NUM_CORES-1:0] BIT0      = NUM_CORES'(1'b1);

   typedef enum logic [1:0] {ST_HOLD, ST_RELEASE, ST_RUN} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [NUM_CORES-1:0]   core_rst_q, core_rst_d;
   logic                   all_out_q, all_out_d;
   logic                   busy_q, busy_d;
   logic                   err_q, err_d;
   logic                   timeout_q, timeout_d;
   logic [CNT_W-1:0]       run_q, run_d;
   logic [SCW-1:0]         cnt_q, cnt_d;
   logic [3:0]             rel_idx_q, rel_idx_d;
   logic [3:0]             sw_idx_q, sw_idx_d;
   logic                   sw_ok_s;

   // Release synchroniser: reset is asserted asynchronously, released through the chain
   always_ff @(posedge QClk or negedge RstQnnnL) begin
      if (!RstQnnnL) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   // State and output registers
   always_ff @(posedge QClk or negedge RstQnnnL) begin
      if (!RstQnnnL) begin
         state_q    <= ST_HOLD;
         core_rst_q <= '1;
         all_out_q  <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         timeout_q  <= 1'b0;
         run_q      <= '0;
         cnt_q      <= '0;
         rel_idx_q  <= 4'd0;
         sw_idx_q   <= 4'd0;
      end else begin
         state_q    <= state_d;
         core_rst_q <= core_rst_d;
         all_out_q  <= all_out_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         timeout_q  <= timeout_d;
         run_q      <= run_d;
         cnt_q      <= cnt_d;
         rel_idx_q  <= rel_idx_d;
         sw_idx_q   <= sw_idx_d;
      end
   end

   // Sequencing, software pulses and watchdog next-state
   always_comb begin
      state_d    = state_q;
      core_rst_d = core_rst_q;
      all_out_d  = all_out_q;
      busy_d     = busy_q;
      timeout_d  = timeout_q;
      run_d      = run_q;
      cnt_d      = cnt_q;
      rel_idx_d  = rel_idx_q;
      sw_idx_d   = sw_idx_q;
      sw_ok_s    = SwRstReq && (state_q == ST_RUN) && !busy_q && ({1'b0, SwRstIdx} < NUM_C5);
      err_d      = SwRstReq && !sw_ok_s;

      case (state_q)
         ST_HOLD: begin
            if (sync_q[SYNC_STAGES-1]) begin
               // Core 0 is freed on the same edge that leaves HOLD
               core_rst_d = core_rst_q & ~BIT0;
               cnt_d      = '0;
               rel_idx_d  = 4'd1;
               if (NUM_CORES == 1) begin
                  state_d   = ST_RUN;
                  all_out_d = 1'b1;
               end else begin
                  state_d = ST_RELEASE;
               end
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_RELEASE: begin
            if (cnt_q == STG_LAST) begin
               core_rst_d = core_rst_q & ~(BIT0 << rel_idx_q);
               cnt_d      = '0;
               rel_idx_d  = rel_idx_q + 4'd1;
               if (rel_idx_q == LAST_CORE) begin
                  state_d   = ST_RUN;
                  all_out_d = 1'b1;
               end else begin
                  state_d = ST_RELEASE;
               end
            end else begin
               cnt_d = cnt_q + SCW'(1'b1);
            end
         end
         ST_RUN: begin
            if (run_q != '1) begin
               run_d = run_q + CNT_W'(1'b1);
            end else begin
               run_d = run_q;
            end
            if ((TIMEOUT != 0) && (run_d == TO_VAL)) begin
               timeout_d = 1'b1;
            end else begin
               timeout_d = timeout_q;
            end
            if (busy_q) begin
               if (cnt_q == STG_LAST) begin
                  core_rst_d = core_rst_q & ~(BIT0 << sw_idx_q);
                  busy_d     = 1'b0;
                  all_out_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + SCW'(1'b1);
               end
            end else if (sw_ok_s) begin
               core_rst_d = core_rst_q | (BIT0 << SwRstIdx);
               busy_d     = 1'b1;
               all_out_d  = 1'b0;
               cnt_d      = '0;
               sw_idx_d   = SwRstIdx;
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase
   end

   assign CoreRstQnnnH = core_rst_q;
   assign AllOutOfRst  = all_out_q;
   assign SwRstBusy    = busy_q;
   assign SwRstErr     = err_q;
   assign Timeout      = timeout_q;
   assign RunCycles    = run_q;

endmodule

// File: tb/tb_lotr_rst_seq.sv
// Bench for lotr_rst_seq: default instance with random software requests, plus a
// single-core instance with the watchdog disabled, both against an edge-count model.
module tb_lotr_rst_seq;

   localparam int N      = 4;
   localparam int S      = 2;
   localparam int STG    = 8;
   localparam int TO     = 1000;
   localparam int CW     = 32;
   localparam int T_LAST = S + 1 + (N - 1) * STG;
   localparam int T1     = S + 1;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          req   = 1'b0;
   logic [3:0]    idx   = 4'd0;
   logic          req1  = 1'b0;
   logic [3:0]    idx1  = 4'd0;

   logic [N-1:0]  core0;
   logic          all0, busy0, err0, to0;
   logic [CW-1:0] run0;
   logic [0:0]    core1;
   logic          all1, busy1, err1, to1;
   logic [CW-1:0] run1;

   int  n_checks = 0;
   int  n_fail   = 0;
   int  e        = 0;
   bit  sw_valid = 1'b0;
   int  sw_start = 0;
   int  sw_end   = 0;
   int  sw_idx_m = 0;
   int  err_due  = -1;

   lotr_rst_seq #(.NUM_CORES(N), .SYNC_STAGES(S), .STAGGER(STG), .TIMEOUT(TO), .CNT_W(CW)) u_dut (
      .QClk(clk), .RstQnnnL(rst_n), .SwRstReq(req), .SwRstIdx(idx),
      .CoreRstQnnnH(core0), .AllOutOfRst(all0), .SwRstBusy(busy0), .SwRstErr(err0),
      .Timeout(to0), .RunCycles(run0)
   );

   lotr_rst_seq #(.NUM_CORES(1), .SYNC_STAGES(S), .STAGGER(1), .TIMEOUT(0), .CNT_W(CW)) u_dut1 (
      .QClk(clk), .RstQnnnL(rst_n), .SwRstReq(req1), .SwRstIdx(idx1),
      .CoreRstQnnnH(core1), .AllOutOfRst(all1), .SwRstBusy(busy1), .SwRstErr(err1),
      .Timeout(to1), .RunCycles(run1)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, act, exp, e, $time);
      end
   endtask

   function automatic bit busy_at(input int k);
      return sw_valid && (k >= sw_start) && (k <= sw_end);
   endfunction

   // Expected outputs after edge e, computed from release times and pulse windows
   task automatic check_all();
      logic [N-1:0] c;
      longint       r;
      bit           b;
      b = busy_at(e);
      for (int i = 0; i < N; i++) begin
         c[i] = (e < S + 1 + i * STG) || (b && (sw_idx_m == i));
      end
      r = (e >= T_LAST) ? longint'(e - T_LAST) : 64'sd0;
      if (r > 64'sd4294967295) r = 64'sd4294967295;
      check_val("core_rst", 64'(core0), 64'(c));
      check_val("all_out", 64'(all0), 64'((e >= T_LAST) && !b));
      check_val("sw_busy", 64'(busy0), 64'(b));
      check_val("sw_err", 64'(err0), 64'(e == err_due));
      check_val("timeout", 64'(to0), 64'((TO > 0) && (e >= T_LAST) && (r >= TO)));
      check_val("run_cycles", 64'(run0), 64'(r));
      check_val("c1_core_rst", 64'(core1), 64'(e < T1));
      check_val("c1_all_out", 64'(all1), 64'(e >= T1));
      check_val("c1_timeout", 64'(to1), 64'd0);
      check_val("c1_run_cycles", 64'(run1), 64'((e >= T1) ? (e - T1) : 0));
      check_val("c1_idle", 64'({busy1, err1}), 64'd0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rst_n) begin
         e++;
         if (req) begin
            if ((e - 1 >= T_LAST) && !busy_at(e - 1) && (int'(idx) < N)) begin
               sw_valid = 1'b1;
               sw_start = e;
               sw_end   = e + STG - 1;
               sw_idx_m = int'(idx);
            end else begin
               err_due = e;
            end
         end
      end
      check_all();
   endtask

   task automatic drive_random(input int pct);
      if ($urandom_range(99, 0) < pct) begin
         req = 1'b1;
         idx = 4'($urandom_range(7, 0));
      end else begin
         req = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench time limit");
   end

   initial begin
      repeat (8) step();
      rst_n = 1'b1;
      repeat (15) begin
         drive_random(30);
         step();
      end
      // Asynchronous reset between edges in the middle of the release sequence
      req = 1'b0;
      #3;
      rst_n    = 1'b0;
      e        = 0;
      sw_valid = 1'b0;
      err_due  = -1;
      #1;
      check_all();
      repeat (4) step();
      rst_n = 1'b1;
      while (e < 5100) begin
         case (e)
            100:     begin req = 1'b1; idx = 4'd2; end
            200:     begin req = 1'b1; idx = 4'd5; end
            202:     begin req = 1'b1; idx = 4'd1; end
            203:     begin req = 1'b1; idx = 4'd0; end
            default: begin
               if ((e < 90) || ((e > 300) && (e < 1150))) drive_random(8);
               else if (e > 1250) drive_random(3);
               else req = 1'b0;
            end
         endcase
         step();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
